shift_seq_ctrl: RTL

Multi-cycle shift sequencer for the MIPS datapath. It executes sll/srl/sra by an arbitrary 5-bit shamt. Each cycle it applies one fixed shift step of 2 bits, or of 1 bit for an odd remainder. A start/busy/done handshake lets the main controller stall while the shift is in progress, and the block replaces a full barrel shifter with a small iterative one.

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_seq_ctrl_step.sv | 22 ++
 rtl/shift_seq_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, op encodings and FSM states for the shift sequencer
package shift_pkg;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_seq_ctrl_step.sv
// shift_step: one combinational shift step of 1 or 2 bits
// work: current value, op_r: latched op, by2: 1 = 2-bit step, 0 = 1-bit step, nxt: shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] work,
    input  logic [1:0]   op_r,
    input  logic         by2,
    output logic [W-1:0] nxt
);
    logic fill;
    logic right;
    always_comb begin
        // op 01 falls through to the left-shift path, same as sll
        right = (op_r == OP_SRL) || (op_r == OP_SRA);
        fill  = (op_r == OP_SRA) & work[W-1];
        nxt   = right ? (by2 ? {{2{fill}}, work[W-1:2]} : {fill, work[W-1:1]})
                      : (by2 ? {work[W-3:0], 2'b00} : {work[W-2:0], 1'b0});
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: iterative sll/srl/sra sequencer with start/busy/done handshake
// clk/reset: clock and async active-high reset; start/op/a/shamt: request sampled in IDLE;
// busy: not IDLE; done: one-cycle result-valid pulse; y: result register
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH   = shift_pkg::WIDTH,
    parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d, y_q, y_d, step_out;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               by2;

    assign by2 = cnt_q > SHAMT_W'(1);

    shift_step #(.W(WIDTH)) u_step (
        .work (work_q),
        .op_r (op_q),
        .by2  (by2),
        .nxt  (step_out)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (start) begin
                work_d  = a;
                cnt_d   = shamt;
                op_d    = op;
                state_d = SHIFT;
            end
            SHIFT: if (cnt_q == '0) begin
                y_d     = work_q;
                state_d = DONE;
            end else begin
                work_d = step_out;
                cnt_d  = cnt_q - (by2 ? SHAMT_W'(2) : SHAMT_W'(1));
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            y_q     <= y_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign y    = y_q;
endmodule
